// File: rtl/v_pkg.sv
// Shared vector-unit definitions: LSU opcodes, LMUL encodings, store FSM states.
// Also carries the default data-memory address width when the build does not set it.
// Helpers translate a latched LMUL into beat count and per-beat bank mask.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 10
`endif

package v_pkg;

   // Store opcodes on v_lsu_op
   localparam logic [3:0] VLSU_VSE8   = 4'd7;
   localparam logic [3:0] VLSU_VSE16  = 4'd8;
   localparam logic [3:0] VLSU_VSE32  = 4'd9;
   localparam logic [3:0] VLSU_VSSE8  = 4'd10;
   localparam logic [3:0] VLSU_VSSE16 = 4'd11;
   localparam logic [3:0] VLSU_VSSE32 = 4'd12;

   // LMUL encodings shared with the load unit
   localparam logic [2:0] LMUL_1    = 3'b000;
   localparam logic [2:0] LMUL_2    = 3'b001;
   localparam logic [2:0] LMUL_4    = 3'b010;
   localparam logic [2:0] LMUL_HALF = 3'b111;

   typedef enum logic [1:0] {IDLE, WRITE, DONE} vstore_state_t;

   // Number of 128-bit beats needed to move the register group
   function automatic logic [2:0] vstore_beats(input logic [2:0] lmul);
      case (lmul)
         LMUL_4:  return 3'd4;
         LMUL_2:  return 3'd2;
         default: return 3'd1;
      endcase
   endfunction

   // Fractional LMUL only covers part of one 128-bit beat
   function automatic logic [3:0] vstore_mask(input logic [2:0] lmul);
      case (lmul)
         LMUL_1, LMUL_2, LMUL_4: return 4'b1111;
         LMUL_HALF:              return 4'b0011;
         default:                return 4'b0001;
      endcase
   endfunction

   function automatic logic is_unit_store(input logic [3:0] op);
      return (op == VLSU_VSE8) || (op == VLSU_VSE16) || (op == VLSU_VSE32);
   endfunction

   function automatic logic is_strided_store(input logic [3:0] op);
      return (op == VLSU_VSSE8) || (op == VLSU_VSSE16) || (op == VLSU_VSSE32);
   endfunction

endpackage

// File: rtl/v_store_beat_sel.sv
// Picks one 128-bit beat of the group image and splits it into four bank words.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is registered.
module v_store_beat_sel
   import v_pkg::*;
#(
   parameter int GRP_W = 512
) (
   input  logic [GRP_W-1:0] img,
   input  logic [1:0]       beat,
   input  logic [3:0]       mask,
   output logic [31:0]      word0,
   output logic [31:0]      word1,
   output logic [31:0]      word2,
   output logic [31:0]      word3,
   output logic [3:0]       we
);

   logic [127:0] slice;

   // Beat k covers image bits [128k+127 : 128k]
   always_comb begin
      slice = img[127:0];
      case (beat)
         2'd0: slice = img[127:0];
         2'd1: slice = img[255:128];
         2'd2: slice = img[383:256];
         2'd3: slice = img[511:384];
         default: slice = img[127:0];
      endcase
   end

   assign word0 = slice[31:0];
   assign word1 = slice[63:32];
   assign word2 = slice[95:64];
   assign word3 = slice[127:96];
   assign we    = mask;

endmodule

// File: rtl/v_storeu.sv
// Vector unit-stride store: writes a latched register-group image to four 32-bit banks.
// Latency: beats in cycles 1..N after start, s_done in cycle N+1, idle again in N+2.
// No backpressure; start is ignored while busy, banks accept a write every cycle.
module v_storeu
   import v_pkg::*;
#(
   parameter int ADDR_W = `DATAMEM_BITS,
   parameter int GRP_W  = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        v_lsu_op,
   input  logic [2:0]        lmul,
   input  logic [2:0]        vsew,
   input  logic [31:0]       s_addr,
   input  logic [GRP_W-1:0]  s_data_in,
   output logic [ADDR_W-1:0] data_addr0,
   output logic [ADDR_W-1:0] data_addr1,
   output logic [ADDR_W-1:0] data_addr2,
   output logic [ADDR_W-1:0] data_addr3,
   output logic [31:0]       s_data_out0,
   output logic [31:0]       s_data_out1,
   output logic [31:0]       s_data_out2,
   output logic [31:0]       s_data_out3,
   output logic              s_we0,
   output logic              s_we1,
   output logic              s_we2,
   output logic              s_we3,
   output logic              busy,
   output logic              s_done
);

   vstore_state_t     state_q, state_d;
   // Index of the next beat to present; beat 0 goes out directly from IDLE
   logic [2:0]        beat_q, beat_d;
   logic [GRP_W-1:0]  img_q, img_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [2:0]        lmul_q, lmul_d;
   logic [2:0]        vsew_q, vsew_d;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [127:0]      dat_q, dat_d;
   logic [3:0]        we_q, we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [GRP_W-1:0]  sel_img;
   logic [1:0]        sel_beat;
   logic [3:0]        sel_mask;
   logic [31:0]       sel_w0, sel_w1, sel_w2, sel_w3;
   logic [3:0]        sel_we;

   v_store_beat_sel #(.GRP_W(GRP_W)) u_sel (
      .img   (sel_img),
      .beat  (sel_beat),
      .mask  (sel_mask),
      .word0 (sel_w0),
      .word1 (sel_w1),
      .word2 (sel_w2),
      .word3 (sel_w3),
      .we    (sel_we)
   );

   // Next-state, operand latching and next bank outputs
   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      img_d    = img_q;
      base_d   = base_q;
      lmul_d   = lmul_q;
      vsew_d   = vsew_q;
      addr_d   = addr_q;
      dat_d    = dat_q;
      we_d     = 4'b0000;
      done_d   = 1'b0;
      sel_img  = img_q;
      sel_beat = beat_q[1:0];
      sel_mask = vstore_mask(lmul_q);

      case (state_q)
         IDLE: begin
            // Beat 0 is taken straight from the inputs so it lands in cycle 1
            sel_img  = s_data_in;
            sel_beat = 2'd0;
            sel_mask = vstore_mask(lmul);
            if (start && is_unit_store(v_lsu_op)) begin
               img_d   = s_data_in;
               base_d  = s_addr[ADDR_W-1:0];
               lmul_d  = lmul;
               vsew_d  = vsew;
               beat_d  = 3'd1;
               addr_d  = s_addr[ADDR_W-1:0];
               dat_d   = {sel_w3, sel_w2, sel_w1, sel_w0};
               we_d    = sel_we;
               state_d = WRITE;
            end else if (start && is_strided_store(v_lsu_op)) begin
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         WRITE: begin
            if (beat_q == vstore_beats(lmul_q)) begin
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               addr_d = base_q + ADDR_W'(beat_q);
               dat_d  = {sel_w3, sel_w2, sel_w1, sel_w0};
               we_d   = sel_we;
               beat_d = beat_q + 3'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered bank outputs; reset drops write enables at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= 3'd0;
         img_q   <= '0;
         base_q  <= '0;
         lmul_q  <= 3'd0;
         vsew_q  <= 3'd0;
         addr_q  <= '0;
         dat_q   <= '0;
         we_q    <= 4'b0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         img_q   <= img_d;
         base_q  <= base_d;
         lmul_q  <= lmul_d;
         vsew_q  <= vsew_d;
         addr_q  <= addr_d;
         dat_q   <= dat_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign data_addr0  = addr_q;
   assign data_addr1  = addr_q;
   assign data_addr2  = addr_q;
   assign data_addr3  = addr_q;
   assign s_data_out0 = dat_q[31:0];
   assign s_data_out1 = dat_q[63:32];
   assign s_data_out2 = dat_q[95:64];
   assign s_data_out3 = dat_q[127:96];
   assign s_we0       = we_q[0];
   assign s_we1       = we_q[1];
   assign s_we2       = we_q[2];
   assign s_we3       = we_q[3];
   assign busy        = busy_q;
   assign s_done      = done_q;

   // Element width is kept for the control path but does not shape unit-stride data;
   // address bits above the bank width are dropped by design (wrap-around)
   logic unused_bits;
   assign unused_bits = ^{vsew_q, s_addr[31:ADDR_W]};

endmodule

// File: tb/tb_v_storeu.sv
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 10
`endif

module tb_v_storeu;

   localparam int AW = `DATAMEM_BITS;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [3:0]    v_lsu_op;
   logic [2:0]    lmul;
   logic [2:0]    vsew;
   logic [31:0]   s_addr;
   logic [511:0]  s_data_in;
   logic [AW-1:0] data_addr0, data_addr1, data_addr2, data_addr3;
   logic [31:0]   s_data_out0, s_data_out1, s_data_out2, s_data_out3;
   logic          s_we0, s_we1, s_we2, s_we3;
   logic          busy, s_done;

   v_storeu dut (
      .clk(clk), .rst(rst), .start(start), .v_lsu_op(v_lsu_op), .lmul(lmul),
      .vsew(vsew), .s_addr(s_addr), .s_data_in(s_data_in),
      .data_addr0(data_addr0), .data_addr1(data_addr1),
      .data_addr2(data_addr2), .data_addr3(data_addr3),
      .s_data_out0(s_data_out0), .s_data_out1(s_data_out1),
      .s_data_out2(s_data_out2), .s_data_out3(s_data_out3),
      .s_we0(s_we0), .s_we1(s_we1), .s_we2(s_we2), .s_we3(s_we3),
      .busy(busy), .s_done(s_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [3:0]    we;
      logic [127:0]  d;
   } beat_t;

   beat_t sb[$];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] mkimg(input logic [31:0] base);
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = base + 32'(i);
      return r;
   endfunction

   function automatic logic [511:0] rndimg();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Reference: expected bank writes for a unit-stride store
   task automatic push_op(input logic [2:0] lm, input logic [31:0] base, input logic [511:0] img);
      int n;
      logic [3:0] m;
      beat_t b;
      case (lm)
         3'b010:  n = 4;
         3'b001:  n = 2;
         default: n = 1;
      endcase
      case (lm)
         3'b000, 3'b001, 3'b010: m = 4'b1111;
         3'b111:                 m = 4'b0011;
         default:                m = 4'b0001;
      endcase
      for (int k = 0; k < n; k++) begin
         b.addr = AW'(base + 32'(k));
         b.we   = m;
         b.d    = img[128*k +: 128];
         sb.push_back(b);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [2:0] lm, input logic [31:0] a,
                        input logic [511:0] img);
      v_lsu_op  = op;
      lmul      = lm;
      vsew      = 3'b010;
      s_addr    = a;
      s_data_in = img;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic check_beat(input string tag);
      beat_t b;
      if (sb.size() == 0) begin
         chk({tag, "_extra_write"}, {s_we3, s_we2, s_we1, s_we0}, 0);
      end else begin
         b = sb.pop_front();
         chk({tag, "_addr"}, {data_addr3, data_addr2, data_addr1, data_addr0}, {4{b.addr}});
         chk({tag, "_data"}, {s_data_out3, s_data_out2, s_data_out1, s_data_out0}, b.d);
         chk({tag, "_we"}, {s_we3, s_we2, s_we1, s_we0}, b.we);
      end
   endtask

   // Runs from cycle 1 until s_done, comparing each write against the scoreboard
   task automatic drain(input string tag, input int exp_done, input bit poke);
      int cyc = 1;
      bit seen = 0;
      while (!seen && cyc <= 16) begin
         chk({tag, "_busy"}, busy, 1);
         if (s_done === 1'b1) begin
            seen = 1;
         end else begin
            if ({s_we3, s_we2, s_we1, s_we0} != 4'b0000) check_beat(tag);
            if (poke && cyc == 1) begin
               v_lsu_op  = 4'd9;
               lmul      = 3'b010;
               s_addr    = 32'h55;
               s_data_in = ~s_data_in;
               start     = 1'b1;
            end
            tick();
            start = 1'b0;
            cyc++;
         end
      end
      chk({tag, "_done_cycle"}, cyc, exp_done);
      chk({tag, "_we_at_done"}, {s_we3, s_we2, s_we1, s_we0}, 0);
      chk({tag, "_beats_left"}, sb.size(), 0);
      sb.delete();
      tick();
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_done"}, s_done, 0);
   endtask

   initial begin
      logic [511:0] img;
      logic [31:0]  amax;

      rst = 1'b1; start = 1'b0; v_lsu_op = 4'd0; lmul = 3'b000; vsew = 3'b000;
      s_addr = 32'h0; s_data_in = '0;
      tick(); tick();
      chk("rst_we", {s_we3, s_we2, s_we1, s_we0}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", s_done, 0);
      chk("rst_addr", {data_addr3, data_addr2, data_addr1, data_addr0}, 0);
      chk("rst_data", {s_data_out3, s_data_out2, s_data_out1, s_data_out0}, 0);
      rst = 1'b0;
      tick();

      // VSE32, single beat
      img = mkimg(32'hA0);
      push_op(3'b000, 32'h10, img);
      issue(4'd9, 3'b000, 32'h10, img);
      drain("vse32_m1", 2, 0);

      // VSE8, four beats
      img = mkimg(32'h100);
      push_op(3'b010, 32'h20, img);
      issue(4'd7, 3'b010, 32'h20, img);
      drain("vse8_m4", 5, 0);

      // VSE16, LMUL 1/2: banks 0,1 only
      img = rndimg();
      push_op(3'b111, 32'h33, img);
      issue(4'd8, 3'b111, 32'h33, img);
      drain("vse16_half", 2, 0);

      // Reserved LMUL: bank 0 only
      img = rndimg();
      push_op(3'b011, 32'h44, img);
      issue(4'd8, 3'b011, 32'h44, img);
      drain("vse16_quarter", 2, 0);

      // Strided store completes with no writes
      issue(4'd12, 3'b010, 32'h80, rndimg());
      drain("vsse32", 1, 0);

      // Unknown opcode is ignored
      issue(4'd3, 3'b000, 32'h90, rndimg());
      chk("badop_busy", busy, 0);
      chk("badop_we", {s_we3, s_we2, s_we1, s_we0}, 0);
      tick();
      chk("badop_done", s_done, 0);

      // Address wrap, plus a second start while busy that must be ignored
      amax = 32'((64'd1 << AW) - 1);
      img = rndimg();
      push_op(3'b001, amax, img);
      issue(4'd9, 3'b001, amax, img);
      drain("wrap_m2", 3, 1);
      tick();
      chk("wrap_no_restart", busy, 0);

      // Reset in the middle of a four-beat store
      img = mkimg(32'h200);
      push_op(3'b010, 32'h40, img);
      issue(4'd7, 3'b010, 32'h40, img);
      check_beat("rst_mid_b0");
      tick();
      check_beat("rst_mid_b1");
      rst = 1'b1;
      #1;
      chk("rst_mid_we", {s_we3, s_we2, s_we1, s_we0}, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", s_done, 0);
      tick();
      chk("rst_hold_done", s_done, 0);
      rst = 1'b0;
      sb.delete();
      tick();
      chk("rst_after_done", s_done, 0);
      chk("rst_after_we", {s_we3, s_we2, s_we1, s_we0}, 0);

      // Normal operation resumes after reset
      img = rndimg();
      push_op(3'b001, 32'h150, img);
      issue(4'd7, 3'b001, 32'h150, img);
      drain("post_rst", 3, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
